// File: rtl/tod_uart_formatter.sv
// rtl/tod_uart_formatter.sv - PPS-triggered 14-byte time-of-day frame sent over an 8N1 UART line
module tod_uart_formatter #(
    parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
    parameter int unsigned BAUD_RATE       = 115200,
    parameter int unsigned TX_DELAY_CYCLES = 1_000_000,
    parameter logic [7:0]  MSG_TYPE        = 8'h01
) (
    input  logic        clk_100mhz,
    input  logic        rst_n_sync,
    input  logic        pps_in,
    input  logic [39:0] time_seconds,
    input  logic [31:0] time_subseconds,
    input  logic [7:0]  status_in,
    input  logic        enable,
    output logic        tod_tx,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [7:0]  overrun_count
);

    localparam int unsigned BIT_CYCLES = CLK_FREQ_HZ / BAUD_RATE;
    localparam int BIT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int DLY_W = (TX_DELAY_CYCLES > 1) ? $clog2(TX_DELAY_CYCLES) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_CYCLES - 1);
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(TX_DELAY_CYCLES - 1);
    localparam logic [3:0] LAST_BYTE = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t           state;
    logic             pps_prev;
    logic [39:0]      sec_q;
    logic [31:0]      sub_q;
    logic [7:0]       status_q;
    logic [7:0]       chk_q;
    logic [DLY_W-1:0] dly_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [3:0]       byte_idx;
    logic [7:0]       shreg;
    logic [7:0]       cur_byte;
    logic             pps_edge;
    logic             bit_wrap;
    logic             chk_byte;

    assign pps_edge = pps_in & ~pps_prev;
    assign bit_wrap = (bit_cnt == BIT_LAST);
    assign chk_byte = (byte_idx >= 4'd2) && (byte_idx <= 4'd12);

    // Byte 13 reads the running checksum, which already holds bytes 2..12.
    always_comb begin
        cur_byte = chk_q;
        case (byte_idx)
            4'd0:    cur_byte = 8'hAA;
            4'd1:    cur_byte = 8'h55;
            4'd2:    cur_byte = MSG_TYPE;
            4'd3:    cur_byte = status_q;
            4'd4:    cur_byte = sec_q[39:32];
            4'd5:    cur_byte = sec_q[31:24];
            4'd6:    cur_byte = sec_q[23:16];
            4'd7:    cur_byte = sec_q[15:8];
            4'd8:    cur_byte = sec_q[7:0];
            4'd9:    cur_byte = sub_q[31:24];
            4'd10:   cur_byte = sub_q[23:16];
            4'd11:   cur_byte = sub_q[15:8];
            4'd12:   cur_byte = sub_q[7:0];
            default: cur_byte = chk_q;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state         <= ST_IDLE;
            pps_prev      <= 1'b0;
            sec_q         <= '0;
            sub_q         <= '0;
            status_q      <= '0;
            chk_q         <= '0;
            dly_cnt       <= '0;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            byte_idx      <= '0;
            shreg         <= '0;
            tod_tx        <= 1'b1;
            busy          <= 1'b0;
            frame_count   <= '0;
            overrun_count <= '0;
        end else begin
            pps_prev <= pps_in;

            // Any edge outside IDLE is dropped, including the cycle busy clears.
            if (pps_edge && (state != ST_IDLE) && (overrun_count != 8'hFF)) begin
                overrun_count <= overrun_count + 8'd1;
            end

            if ((state == ST_START) || (state == ST_DATA) || (state == ST_STOP)) begin
                bit_cnt <= bit_wrap ? '0 : bit_cnt + BIT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (pps_edge && enable) begin
                        sec_q    <= time_seconds;
                        sub_q    <= time_subseconds;
                        status_q <= status_in;
                        chk_q    <= '0;
                        dly_cnt  <= DLY_LOAD;
                        busy     <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dly_cnt == '0) begin
                        byte_idx <= '0;
                        bit_cnt  <= '0;
                        tod_tx   <= 1'b0;
                        state    <= ST_START;
                    end else begin
                        dly_cnt <= dly_cnt - DLY_W'(1);
                    end
                end
                ST_START: begin
                    if (bit_wrap) begin
                        tod_tx  <= cur_byte[0];
                        shreg   <= {1'b0, cur_byte[7:1]};
                        bit_idx <= '0;
                        if (chk_byte) begin
                            chk_q <= chk_q ^ cur_byte;
                        end
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_wrap) begin
                        if (bit_idx == 3'd7) begin
                            tod_tx <= 1'b1;
                            state  <= ST_STOP;
                        end else begin
                            tod_tx  <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_wrap) begin
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx <= byte_idx + 4'd1;
                            tod_tx   <= 1'b0;
                            state    <= ST_START;
                        end else begin
                            frame_count <= frame_count + 16'd1;
                            busy        <= 1'b0;
                            state       <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    tod_tx <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tod_uart_formatter.sv
// tb/tb_tod_uart_formatter.sv - directed bench for tod_uart_formatter with a UART frame decoder
module tb_tod_uart_formatter;

    localparam int BIT = 10;

    logic        clk_100mhz;
    logic        rst_n_sync;
    logic        pps_in;
    logic [39:0] time_seconds;
    logic [31:0] time_subseconds;
    logic [7:0]  status_in;
    logic        enable;
    logic        tod_tx;
    logic        busy;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;

    int          cyc;
    int          n_checks;
    int          n_errors;
    logic [7:0]  rx_b  [14];
    logic [7:0]  exp_b [14];

    tod_uart_formatter #(
        .CLK_FREQ_HZ     (1000),
        .BAUD_RATE       (100),
        .TX_DELAY_CYCLES (5),
        .MSG_TYPE        (8'h01)
    ) dut (
        .clk_100mhz      (clk_100mhz),
        .rst_n_sync      (rst_n_sync),
        .pps_in          (pps_in),
        .time_seconds    (time_seconds),
        .time_subseconds (time_subseconds),
        .status_in       (status_in),
        .enable          (enable),
        .tod_tx          (tod_tx),
        .busy            (busy),
        .frame_count     (frame_count),
        .overrun_count   (overrun_count)
    );

    initial clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    initial cyc = 0;
    always @(posedge clk_100mhz) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic pulse_pps(output int cap);
        @(negedge clk_100mhz);
        pps_in = 1'b1;
        cap = cyc + 1;
        @(negedge clk_100mhz);
        pps_in = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk_100mhz);
    endtask

    task automatic wait_idle(output int t);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk_100mhz);
            n++;
        end
        check("wait_idle_timeout", 64'(n < 3000), 64'd1);
        t = cyc;
    endtask

    task automatic rx_byte(output logic [7:0] b, output bit ok, output int t);
        int n;
        n  = 0;
        ok = 1'b0;
        b  = '0;
        t  = 0;
        while (tod_tx !== 1'b0) begin
            if (n >= 3000) return;
            @(negedge clk_100mhz);
            n++;
        end
        t = cyc;
        repeat (BIT / 2 - 1) @(negedge clk_100mhz);
        if (tod_tx !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk_100mhz);
            b[i] = tod_tx;
        end
        repeat (BIT) @(negedge clk_100mhz);
        ok = (tod_tx === 1'b1);
    endtask

    task automatic rx_frame(output int fall);
        logic [7:0] b;
        bit         ok;
        int         t;
        fall = -1;
        for (int i = 0; i < 14; i++) begin
            rx_byte(b, ok, t);
            check($sformatf("rx_ok_b%0d", i), 64'(ok), 64'd1);
            if (!ok) return;
            if (i == 0) fall = t;
            rx_b[i] = b;
        end
    endtask

    task automatic build_exp(input logic [39:0] s, input logic [31:0] u, input logic [7:0] st);
        logic [7:0] x;
        exp_b[0]  = 8'hAA;
        exp_b[1]  = 8'h55;
        exp_b[2]  = 8'h01;
        exp_b[3]  = st;
        exp_b[4]  = s[39:32];
        exp_b[5]  = s[31:24];
        exp_b[6]  = s[23:16];
        exp_b[7]  = s[15:8];
        exp_b[8]  = s[7:0];
        exp_b[9]  = u[31:24];
        exp_b[10] = u[23:16];
        exp_b[11] = u[15:8];
        exp_b[12] = u[7:0];
        x = 8'h00;
        for (int i = 2; i <= 12; i++) x = x ^ exp_b[i];
        exp_b[13] = x;
    endtask

    task automatic check_frame(input string tag);
        for (int i = 0; i < 14; i++) begin
            check($sformatf("%s_b%0d", tag, i), 64'(rx_b[i]), 64'(exp_b[i]));
        end
    endtask

    initial begin
        int  cap;
        int  cap_x;
        int  fall;
        int  t_idle;
        bit  low_seen;

        n_checks        = 0;
        n_errors        = 0;
        rst_n_sync      = 1'b0;
        pps_in          = 1'b0;
        time_seconds    = '0;
        time_subseconds = '0;
        status_in       = '0;
        enable          = 1'b1;
        for (int i = 0; i < 14; i++) rx_b[i] = 8'h00;

        repeat (3) @(negedge clk_100mhz);
        check("reset_tod_tx", 64'(tod_tx), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_frame_count", 64'(frame_count), 64'd0);
        check("reset_overrun", 64'(overrun_count), 64'd0);
        rst_n_sync = 1'b1;
        repeat (3) @(negedge clk_100mhz);

        // Frame 1: inputs change during WAIT and DATA, extra PPS at +200.
        time_seconds    = 40'h12_3456_789A;
        time_subseconds = 32'h8000_0000;
        status_in       = 8'h3C;
        pulse_pps(cap);
        fork
            rx_frame(fall);
            begin
                wait_until(cap + 2);
                time_seconds = 40'h0;
                wait_until(cap + 200);
                pulse_pps(cap_x);
                wait_until(cap + 300);
                time_seconds = 40'h0;
            end
        join
        build_exp(40'h12_3456_789A, 32'h8000_0000, 8'h3C);
        check("f1_start_latency", 64'(fall - cap), 64'd5);
        check_frame("f1");
        check("f1_checksum_2f", 64'(rx_b[13]), 64'h2F);
        wait_idle(t_idle);
        check("f1_busy_cycles", 64'(t_idle - cap), 64'd1405);
        check("f1_frame_count", 64'(frame_count), 64'd1);
        check("f1_overrun", 64'(overrun_count), 64'd1);
        wait_until(cap + 1900);
        check("f1_no_second_busy", 64'(busy), 64'd0);
        check("f1_no_second_tx", 64'(tod_tx), 64'd1);

        // Frame 2: PPS 2000 cycles after the first.
        wait_until(cap + 1998);
        time_seconds    = 40'h00_0000_0001;
        time_subseconds = 32'hFFFF_FFFF;
        status_in       = 8'h00;
        pulse_pps(cap_x);
        check("f2_pps_offset", 64'(cap_x - cap), 64'd2000);
        rx_frame(fall);
        build_exp(40'h00_0000_0001, 32'hFFFF_FFFF, 8'h00);
        check_frame("f2");
        wait_idle(t_idle);
        check("f2_frame_count", 64'(frame_count), 64'd2);

        // enable low at PPS: nothing starts, no overrun.
        enable = 1'b0;
        pulse_pps(cap);
        low_seen = 1'b0;
        repeat (50) begin
            @(negedge clk_100mhz);
            if (tod_tx !== 1'b1) low_seen = 1'b1;
        end
        check("dis_tx_low_seen", 64'(low_seen), 64'd0);
        check("dis_busy", 64'(busy), 64'd0);
        check("dis_overrun", 64'(overrun_count), 64'd1);

        // enable dropped mid-frame: full frame still goes out.
        enable          = 1'b1;
        time_seconds    = 40'hFF_FFFF_FFFF;
        time_subseconds = 32'h0102_0304;
        status_in       = 8'hA5;
        pulse_pps(cap);
        fork
            rx_frame(fall);
            begin
                repeat (300) @(negedge clk_100mhz);
                enable = 1'b0;
            end
        join
        build_exp(40'hFF_FFFF_FFFF, 32'h0102_0304, 8'hA5);
        check_frame("f3");
        wait_idle(t_idle);
        check("f3_frame_count", 64'(frame_count), 64'd3);
        pulse_pps(cap);
        repeat (20) @(negedge clk_100mhz);
        check("f3_after_dis_busy", 64'(busy), 64'd0);
        check("f3_after_dis_overrun", 64'(overrun_count), 64'd1);
        enable = 1'b1;

        // Reset during the start bit of byte 6.
        time_seconds    = 40'h12_3456_789A;
        time_subseconds = 32'h8000_0000;
        status_in       = 8'h3C;
        pulse_pps(cap);
        begin
            logic [7:0] b;
            bit         ok;
            int         t;
            int         n;
            for (int i = 0; i < 6; i++) rx_byte(b, ok, t);
            check("rst_pre_ok", 64'(ok), 64'd1);
            n = 0;
            while (tod_tx !== 1'b0 && n < 200) begin
                @(negedge clk_100mhz);
                n++;
            end
            check("rst_pre_start_bit", 64'(tod_tx), 64'd0);
        end
        #2;
        rst_n_sync = 1'b0;
        #1;
        check("rst_async_tod_tx", 64'(tod_tx), 64'd1);
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_overrun", 64'(overrun_count), 64'd0);
        @(negedge clk_100mhz);
        rst_n_sync = 1'b1;
        repeat (3) @(negedge clk_100mhz);
        time_seconds    = 40'h01_0203_0405;
        time_subseconds = 32'h0607_0809;
        status_in       = 8'h81;
        pulse_pps(cap);
        rx_frame(fall);
        build_exp(40'h01_0203_0405, 32'h0607_0809, 8'h81);
        check("f4_start_latency", 64'(fall - cap), 64'd5);
        check_frame("f4");
        wait_idle(t_idle);
        check("f4_frame_count", 64'(frame_count), 64'd1);

        // frame_count wrap and overrun saturation.
        force dut.frame_count = 16'hFFFF;
        #1;
        release dut.frame_count;
        check("wrap_preset", 64'(frame_count), 64'hFFFF);
        time_seconds    = 40'hDE_ADBE_EF00;
        time_subseconds = 32'h1234_5678;
        status_in       = 8'h7E;
        pulse_pps(cap);
        fork
            rx_frame(fall);
            begin
                wait_until(cap + 10);
                repeat (300) begin
                    pulse_pps(cap_x);
                    repeat (2) @(negedge clk_100mhz);
                end
            end
        join
        build_exp(40'hDE_ADBE_EF00, 32'h1234_5678, 8'h7E);
        check_frame("f5");
        wait_idle(t_idle);
        check("wrap_frame_count", 64'(frame_count), 64'h0000);
        check("overrun_saturate", 64'(overrun_count), 64'hFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tod_uart_formatter.md
Name: tod_uart_formatter

Overview:
Downstream consumer of the PPS generator top outputs (pps_out, time_seconds, time_subseconds, debug_status). On each PPS rising edge it snapshots the time and status. After a programmable delay it serialises a 14-byte binary Time-of-Day frame over an 8N1 UART line for external equipment. Single clock domain; pps_in is already synchronous to clk_100mhz.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency in Hz.
BAUD_RATE, 115200, UART bit rate. Bit period BIT_CYCLES = CLK_FREQ_HZ/BAUD_RATE, integer divide (868 at defaults).
TX_DELAY_CYCLES, 1_000_000, cycles from PPS capture to start bit. Must be >= 1.
MSG_TYPE, 8'h01, frame type byte.

Ports:
clk_100mhz  in  1  system clock
rst_n_sync  in  1  reset
pps_in  in  1  PPS pulse, synchronous, width >= 1 cycle
time_seconds  in  40  seconds since 2000 at the PPS edge
time_subseconds  in  32  subseconds at the PPS edge
status_in  in  8  status byte (debug_status)
enable  in  1  permits new frames to start
tod_tx  out  1  UART TX line, idle high
busy  out  1  high from capture until the stop bit of byte 13 ends
frame_count  out  16  frames completed, wraps
overrun_count  out  8  PPS edges dropped while busy, saturating

Behaviour:
- Reset (already decided): rst_n_sync, asynchronous, active-low; clock clk_100mhz.
- Reset values: tod_tx=1, busy=0, frame_count=0, overrun_count=0. FSM goes to IDLE and all counters and snapshot registers clear.
- Edge detect: registered pps_prev. An edge is a cycle with pps_in=1 and pps_prev=0. No edge is detected in the first cycle after reset unless pps_prev=0 and pps_in=1.
- FSM states: IDLE, WAIT, START, DATA, STOP.
  - IDLE, on edge with enable=1: load the snapshot (seconds, subseconds, status), clear the checksum, load the delay counter with TX_DELAY_CYCLES-1, go to WAIT. busy goes high on that same clock edge.
  - IDLE, on edge with enable=0: no action, no overrun.
  - WAIT: decrement the delay counter. At 0, go to START with byte index 0. The start bit begins exactly TX_DELAY_CYCLES cycles after the capture edge.
  - START: tod_tx=0 for BIT_CYCLES, then go to DATA.
  - DATA: 8 bits, LSB first, each held BIT_CYCLES, then go to STOP.
  - STOP: tod_tx=1 for BIT_CYCLES. If byte index < 13, increment it and go to START. Otherwise increment frame_count, clear busy, go to IDLE.
- Frame byte order:
  - 0: 8'hAA
  - 1: 8'h55
  - 2: MSG_TYPE
  - 3: status
  - 4..8: seconds, big-endian (byte 4 = bits 39:32)
  - 9..12: subseconds, big-endian
  - 13: checksum
- Checksum: 8-bit XOR of bytes 2..12. Accumulate each byte as it is loaded for transmission, so byte 13 needs no extra cycle.
- Back-to-back stop/start: no idle gap between bytes.
- Frame duration: 14*10*BIT_CYCLES cycles.
- Snapshot inputs are sampled only on the capture edge. Later input changes do not affect the frame in flight.
- Edge while busy (any state except IDLE): ignored. overrun_count increments and saturates at 8'hFF. The frame in flight is unaffected.
- Edge in the same cycle busy clears (STOP to IDLE transition): counts as an overrun; no new frame starts.
- enable deasserted mid-frame: the current frame completes; later edges are ignored without overrun.
- frame_count wraps from 16'hFFFF to 16'h0000.
- Reset mid-frame: tod_tx returns high immediately (asynchronous); the partial frame is abandoned.
- Bit timing counter: counts 0..BIT_CYCLES-1. The line changes only on a counter wrap.

Test Plan:
1. Use CLK_FREQ_HZ=1000, BAUD_RATE=100 (BIT_CYCLES=10), TX_DELAY_CYCLES=5. Stimulus: seconds=40'h12_3456_789A, subseconds=32'h8000_0000, status=8'h3C, 1-cycle PPS. Required: tod_tx falls 5 cycles after capture; decoded bytes AA 55 01 3C 12 34 56 78 9A 80 00 00 00 2F; busy high for 5+1400 cycles; frame_count=1.
2. Change time_seconds to 40'h0 during WAIT and during DATA -> frame still carries 12 34 56 78 9A.
3. Second PPS 200 cycles after the first -> frame 1 is unchanged, overrun_count=1, no second frame. PPS 2000 cycles after the first -> second frame sent, frame_count=2.
4. enable=0 at PPS -> tod_tx stays 1, busy=0, overrun_count=0. Deassert enable mid-frame -> the full 14 bytes are still sent.
5. Assert rst_n_sync low during byte 6 -> tod_tx=1 and busy=0 asynchronously. The next PPS after release produces a complete, correct frame.
6. Force frame_count to 16'hFFFF, complete one frame -> 16'h0000. Send 300 overrun edges -> overrun_count holds at 8'hFF.
